// File: rtl/comparator_serial.sv
// Nibble-serial magnitude comparator with 74HC85-style cascade seeding, LSB nibble first.
// Optional abort input enabled by defining CMP_ABORT_EN.
module comparator_serial #(
    parameter int NIBBLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Igt,
    input  logic       Ilt,
    input  logic       Ieq,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       nib_valid,
`ifdef CMP_ABORT_EN
    input  logic       abort,
`endif
    output logic       nib_ready,
    output logic       busy,
    output logic       done,
    output logic       Fgt,
    output logic       Flt,
    output logic       Feq
);

    localparam int CW = $clog2(NIBBLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    rel_q;
    logic [2:0]    res_q;
    logic          nib_ready_q, busy_q, done_q;

    logic [2:0] seed_d, rel_d;
    logic       accept, abort_w;

`ifdef CMP_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign accept = nib_valid & nib_ready_q;

    // Seed decode: equal dominates; conflicting or empty gt/lt cascade into 000/110.
    always_comb begin
        seed_d = 3'b001;
        if (!Ieq) begin
            case ({Igt, Ilt})
                2'b10:   seed_d = 3'b100;
                2'b01:   seed_d = 3'b010;
                2'b11:   seed_d = 3'b000;
                default: seed_d = 3'b110;
            endcase
        end
    end

    // A higher-order nibble that differs overrides everything below it.
    always_comb begin
        rel_d = rel_q;
        if (A > B)      rel_d = 3'b100;
        else if (A < B) rel_d = 3'b010;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rel_q       <= 3'b001;
            res_q       <= 3'b001;
            nib_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rel_q       <= seed_d;
                        cnt_q       <= '0;
                        state_q     <= RUN;
                        nib_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_w) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        nib_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (accept) begin
                        rel_q <= rel_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q     <= DONE;
                            nib_ready_q <= 1'b0;
                            done_q      <= 1'b1;
                            res_q       <= rel_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    nib_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign nib_ready       = nib_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign {Fgt, Flt, Feq} = res_q;

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench for comparator_serial: expected relations are queued at stimulus time
// and checked against each done pulse.
module tb_comparator_serial;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst, start, Igt, Ilt, Ieq, nib_valid;
    logic [3:0] A, B;
    logic       nib_ready, busy, done, Fgt, Flt, Feq;
`ifdef CMP_ABORT_EN
    logic       abort;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_seen = 0;
    int spurious = 0;
    logic [2:0] sb[$];

    always #5 clk = ~clk;

    comparator_serial #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .Igt(Igt), .Ilt(Ilt), .Ieq(Ieq),
        .A(A), .B(B), .nib_valid(nib_valid),
`ifdef CMP_ABORT_EN
        .abort(abort),
`endif
        .nib_ready(nib_ready), .busy(busy), .done(done),
        .Fgt(Fgt), .Flt(Flt), .Feq(Feq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] model(input logic gt, lt, eq, input logic [15:0] a, b);
        logic [2:0] r;
        if (eq)             r = 3'b001;
        else if (gt && !lt) r = 3'b100;
        else if (!gt && lt) r = 3'b010;
        else if (gt && lt)  r = 3'b000;
        else                r = 3'b110;
        for (int i = 0; i < N; i++) begin
            if (a[4*i +: 4] > b[4*i +: 4])      r = 3'b100;
            else if (a[4*i +: 4] < b[4*i +: 4]) r = 3'b010;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) spurious++;
            else chk("result", {29'd0, Fgt, Flt, Feq}, {29'd0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic gt, lt, eq);
        start = 1'b1; Igt = gt; Ilt = lt; Ieq = eq;
        tick();
        start = 1'b0; Igt = 1'b0; Ilt = 1'b0; Ieq = 1'b0;
        chk("busy_run", {31'd0, busy}, 32'd1);
    endtask

    // Streams nbeats nibble pairs; gap idle cycles between beats, optionally pulsing start in gaps.
    task automatic beats(input logic [15:0] a, b, input int first, nbeats, gap, input logic poke);
        for (int i = first; i < first + nbeats; i++) begin
            A = a[4*i +: 4]; B = b[4*i +: 4]; nib_valid = 1'b1;
            chk("nib_ready", {31'd0, nib_ready}, 32'd1);
            tick();
            nib_valid = 1'b0; A = ~A; B = 4'h5;
            if (i != N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    start = poke; Igt = 1'b1; Ieq = 1'b0;
                    tick();
                    start = 1'b0; Igt = 1'b0;
                end
            end
        end
    endtask

    task automatic compare(input logic gt, lt, eq, input logic [15:0] a, b,
                           input int gap, input logic poke);
        sb.push_back(model(gt, lt, eq, a, b));
        kick(gt, lt, eq);
        beats(a, b, 0, N, gap, poke);
        chk("done_latency", {31'd0, done}, 32'd1);
        chk("ready_in_done", {31'd0, nib_ready}, 32'd0);
        tick();
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_F"}, {29'd0, Fgt, Flt, Feq}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, nib_ready}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; Igt = 1'b0; Ilt = 1'b0; Ieq = 1'b0;
        A = '0; B = '0; nib_valid = 1'b0;
`ifdef CMP_ABORT_EN
        abort = 1'b0;
`endif
        tick(); tick();
        chk_reset_outs("rst_init");
        rst = 1'b0;
        tick();

        compare(1'b0, 1'b0, 1'b1, 16'h1234, 16'h1234, 0, 1'b0);
        compare(1'b0, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 0, 1'b0);
        chk("hold_idle", {29'd0, Fgt, Flt, Feq}, 32'h4);
        tick(); tick();
        chk("hold_idle2", {29'd0, Fgt, Flt, Feq}, 32'h4);

        // Reset while idle clears a held Fgt result.
        rst = 1'b1; #1;
        chk_reset_outs("rst_idle");
        tick(); rst = 1'b0; tick();

        compare(1'b1, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 0, 1'b0);
        compare(1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 0, 1'b0);
        compare(1'b1, 1'b1, 1'b0, 16'h0F0F, 16'h0F0F, 0, 1'b0);
        compare(1'b0, 1'b0, 1'b1, 16'h0001, 16'h1000, 0, 1'b0);

        // Stalls with start poked mid-run must not disturb the result.
        d0 = done_seen;
        compare(1'b0, 1'b0, 1'b1, 16'h3A5C, 16'h3A6C, 3, 1'b1);
        chk("one_done", done_seen - d0, 32'd1);

        // Reset after two beats discards the partial comparison.
        d0 = done_seen;
        kick(1'b0, 1'b0, 1'b1);
        beats(16'h00F0, 16'h0010, 0, 2, 0, 1'b0);
        chk("F_unchanged_run", {29'd0, Fgt, Flt, Feq}, 32'h2);
        rst = 1'b1; #1;
        chk_reset_outs("rst_run");
        tick(); rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("no_done_rst", done_seen - d0, 32'd0);

`ifdef CMP_ABORT_EN
        compare(1'b0, 1'b0, 1'b1, 16'h0900, 16'h0100, 0, 1'b0);
        d0 = done_seen;
        kick(1'b0, 1'b0, 1'b1);
        beats(16'h0000, 16'h00FF, 0, 2, 0, 1'b0);
        abort = 1'b1; nib_valid = 1'b1; A = 4'h0; B = 4'hF;
        tick();
        abort = 1'b0; nib_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, nib_ready}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_no_done", done_seen - d0, 32'd0);
        chk("abort_F_held", {29'd0, Fgt, Flt, Feq}, 32'h4);
        compare(1'b0, 1'b0, 1'b1, 16'h1111, 16'h1112, 0, 1'b0);
`endif

        tick();
        chk("spurious_done", spurious, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
